// File: rtl/adder_axi_pkg.sv
// Shared constants and state type for the adder AXI4-Lite master.
// Offsets, CTRL/STAT encodings, completion codes and the sequencer states.
package adder_axi_pkg;

  localparam logic [7:0] REG_A    = 8'h00;
  localparam logic [7:0] REG_B    = 8'h04;
  localparam logic [7:0] REG_CTRL = 8'h08;
  localparam logic [7:0] REG_STAT = 8'h0C;
  localparam logic [7:0] REG_RES  = 8'h10;

  localparam logic [31:0] CTRL_GO        = 32'hFFFF_FFFF;
  localparam logic [31:0] STAT_DONE_MASK = 32'h0FFF_FFFF;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_BUS     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_A,
    S_WR_B,
    S_WR_GO,
    S_POLL,
    S_RD_RES,
    S_WR_CLR,
    S_DONE
  } state_e;

  function automatic logic stat_done(input logic [31:0] s);
    return (s & STAT_DONE_MASK) == STAT_DONE_MASK;
  endfunction

endpackage

// File: rtl/axi_lite_master_xfer.sv
// Single AXI4-Lite transaction engine: one read or write per request.
// done pulses in the response handshake cycle; a new read may start then.
module axi_lite_master_xfer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    resp,
  output logic [AW-1:0] m_axi_awaddr,
  output logic          m_axi_awvalid,
  input  logic          m_axi_awready,
  output logic [DW-1:0] m_axi_wdata,
  output logic [3:0]    m_axi_wstrb,
  output logic          m_axi_wvalid,
  input  logic          m_axi_wready,
  input  logic [1:0]    m_axi_bresp,
  input  logic          m_axi_bvalid,
  output logic          m_axi_bready,
  output logic [AW-1:0] m_axi_araddr,
  output logic          m_axi_arvalid,
  input  logic          m_axi_arready,
  input  logic [DW-1:0] m_axi_rdata,
  input  logic [1:0]    m_axi_rresp,
  input  logic          m_axi_rvalid,
  output logic          m_axi_rready
);

  logic          awvalid_q, awvalid_d;
  logic          wvalid_q, wvalid_d;
  logic          bready_q, bready_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic active, aw_left, w_left, b_hs, r_hs, ar_hs, start;

  // Channel handshakes and next values of every bus flop.
  always_comb begin
    active  = awvalid_q | wvalid_q | bready_q | arvalid_q | rready_q;
    aw_left = awvalid_q & ~m_axi_awready;
    w_left  = wvalid_q & ~m_axi_wready;
    b_hs    = bready_q & m_axi_bvalid;
    r_hs    = rready_q & m_axi_rvalid;
    ar_hs   = arvalid_q & m_axi_arready;
    done    = b_hs | r_hs;
    start   = req & (~active | done);

    awvalid_d = aw_left;
    wvalid_d  = w_left;
    arvalid_d = arvalid_q & ~m_axi_arready;
    bready_d  = (bready_q & ~m_axi_bvalid)
              | ((awvalid_q | wvalid_q) & ~aw_left & ~w_left);
    rready_d  = (rready_q & ~m_axi_rvalid) | ar_hs;
    addr_d    = addr_q;
    wdata_d   = wdata_q;

    if (start) begin
      addr_d  = addr;
      wdata_d = wdata;
      if (we) begin
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
      end else begin
        arvalid_d = 1'b1;
      end
    end
  end

  // Bus-side registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rdata         = m_axi_rdata;
  assign resp          = r_hs ? m_axi_rresp : m_axi_bresp;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: rtl/adder_axi_master.sv
// Sequencer driving the AXI4-Lite adder: A, B, GO, poll, RES, clear.
// One bus request per state; errors abort to DONE without clearing CTRL.
module adder_axi_master
  import adder_axi_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = '0,
  parameter int POLL_LIMIT = 1000
) (
  input  logic                        axi_aclk,
  input  logic                        axi_areset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [31:0]                 cmd_a,
  input  logic [31:0]                 cmd_b,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [31:0]                 res_data,
  output logic [1:0]                  res_err,
  output logic                        busy,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [C_AXI_DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]                  m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [C_AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [C_AXI_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int PCW =
    ($clog2(POLL_LIMIT + 1) > 10) ? $clog2(POLL_LIMIT + 1) : 10;

  state_e           state_q, state_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [1:0]       res_err_q, res_err_d;
  logic [PCW-1:0]   poll_cnt_q, poll_cnt_d, poll_inc;
  logic             pending_q, pending_d;

  logic                        x_req, x_we, x_done;
  logic [C_AXI_ADDR_WIDTH-1:0] x_addr;
  logic [31:0]                 x_wdata, x_rdata;
  logic [1:0]                  x_resp;
  logic [7:0]                  off;
  logic bus_state, bus_err, stat_ok, poll_last, repoll;

  assign poll_inc  = poll_cnt_q + 1'b1;
  assign poll_last = poll_inc == PCW'(POLL_LIMIT);
  assign bus_err   = x_resp != 2'b00;
  assign stat_ok   = stat_done(x_rdata);
  assign repoll    = (state_q == S_POLL) & x_done & ~bus_err
                   & ~stat_ok & ~poll_last;

  // State register.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state plus operand, result and poll-counter updates.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    poll_cnt_d = poll_cnt_q;
    unique case (state_q)
      S_IDLE: if (cmd_valid) begin
        a_d        = cmd_a;
        b_d        = cmd_b;
        res_data_d = '0;
        res_err_d  = ERR_OK;
        poll_cnt_d = '0;
        state_d    = S_WR_A;
      end
      S_DONE: if (res_ready) state_d = S_IDLE;
      default: if (x_done) begin
        if (bus_err) begin
          res_data_d = '0;
          if (res_err_q == ERR_OK) res_err_d = ERR_BUS;
          state_d = S_DONE;
        end else begin
          unique case (state_q)
            S_WR_A:  state_d = S_WR_B;
            S_WR_B:  state_d = S_WR_GO;
            S_WR_GO: state_d = S_POLL;
            S_POLL: begin
              if (stat_ok) begin
                state_d = S_RD_RES;
              end else if (poll_last) begin
                res_err_d  = ERR_TIMEOUT;
                res_data_d = '0;
                state_d    = S_WR_CLR;
              end else begin
                poll_cnt_d = poll_inc;
              end
            end
            S_RD_RES: begin
              res_data_d = x_rdata;
              state_d    = S_WR_CLR;
            end
            S_WR_CLR: state_d = S_DONE;
            default:  state_d = state_q;
          endcase
        end
      end
    endcase
  end

  // Operand, result, poll count and request-issued flag registers.
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      a_q        <= '0;
      b_q        <= '0;
      res_data_q <= '0;
      res_err_q  <= ERR_OK;
      poll_cnt_q <= '0;
      pending_q  <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      poll_cnt_q <= poll_cnt_d;
      pending_q  <= pending_d;
    end
  end

  // Handshake outputs and the per-state bus request.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    bus_state = 1'b1;
    x_we      = 1'b1;
    off       = REG_A;
    x_wdata   = '0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        bus_state = 1'b0;
      end
      S_WR_A: begin
        off     = REG_A;
        x_wdata = a_q;
      end
      S_WR_B: begin
        off     = REG_B;
        x_wdata = b_q;
      end
      S_WR_GO: begin
        off     = REG_CTRL;
        x_wdata = CTRL_GO;
      end
      S_POLL: begin
        off  = REG_STAT;
        x_we = 1'b0;
      end
      S_RD_RES: begin
        off  = REG_RES;
        x_we = 1'b0;
      end
      S_WR_CLR: begin
        off     = REG_CTRL;
        x_wdata = '0;
      end
      S_DONE: begin
        res_valid = 1'b1;
        bus_state = 1'b0;
      end
    endcase
    busy      = state_q != S_IDLE;
    x_addr    = C_BASE_ADDR + C_AXI_ADDR_WIDTH'(off);
    x_req     = bus_state & (~pending_q | repoll);
    pending_d = x_req | (pending_q & ~x_done);
  end

  assign res_data = res_data_q;
  assign res_err  = res_err_q;

  axi_lite_master_xfer #(
    .AW (C_AXI_ADDR_WIDTH),
    .DW (C_AXI_DATA_WIDTH)
  ) u_xfer (
    .clk           (axi_aclk),
    .rst           (axi_areset),
    .req           (x_req),
    .we            (x_we),
    .addr          (x_addr),
    .wdata         (x_wdata),
    .done          (x_done),
    .rdata         (x_rdata),
    .resp          (x_resp),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready)
  );

endmodule

// File: tb/tb_adder_axi_master.sv
// Bench for adder_axi_master against a behavioural AXI4-Lite adder slave.
// Results are scored from a queue of expected sum/code pairs.
module tb_adder_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [1:0]  res_err;
  logic        busy;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  adder_axi_master #(
    .C_AXI_ADDR_WIDTH (32),
    .C_AXI_DATA_WIDTH (32),
    .C_BASE_ADDR      (32'h0),
    .POLL_LIMIT       (8)
  ) dut (
    .axi_aclk      (clk),
    .axi_areset    (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_err       (res_err),
    .busy          (busy),
    .m_axi_awaddr  (awaddr),
    .m_axi_awvalid (awvalid),
    .m_axi_awready (awready),
    .m_axi_wdata   (wdata),
    .m_axi_wstrb   (wstrb),
    .m_axi_wvalid  (wvalid),
    .m_axi_wready  (wready),
    .m_axi_bresp   (bresp),
    .m_axi_bvalid  (bvalid),
    .m_axi_bready  (bready),
    .m_axi_araddr  (araddr),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
  } exp_t;

  // slave configuration, written only by the stimulus process
  int   aw_dly, w_dly, stat_zero_n;
  bit   stat_never, b_err;
  logic sl_clr;

  // slave state, written only by the slave process
  int          aw_cnt, w_cnt, stat_reads;
  logic        aw_have, w_have;
  logic [31:0] aw_a, w_d, ra, rb, rctrl, rd_val, wa, wd;
  logic        aw_hs, w_hs, ar_hs, wr_fire;
  txn_t        log_q[$];
  exp_t        exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);
  assign arready = arvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign wa      = aw_have ? aw_a : awaddr;
  assign wd      = w_have ? w_d : wdata;
  assign wr_fire = (aw_have || aw_hs) && (w_have || w_hs) && !bvalid;

  always_comb begin
    rd_val = 32'h0;
    case (araddr[7:0])
      8'h00: rd_val = ra;
      8'h04: rd_val = rb;
      8'h08: rd_val = rctrl;
      8'h0C: rd_val = (stat_never || stat_reads < stat_zero_n)
                      ? 32'h0 : 32'h0FFF_FFFF;
      8'h10: rd_val = ra + rb;
      default: rd_val = 32'h0;
    endcase
  end

  always @(posedge clk or posedge rst) begin
    if (rst || sl_clr) begin
      aw_cnt <= 0; w_cnt <= 0; stat_reads <= 0;
      aw_have <= 0; w_have <= 0; aw_a <= 0; w_d <= 0;
      ra <= 0; rb <= 0; rctrl <= 0;
      bvalid <= 0; bresp <= 0; rvalid <= 0; rresp <= 0; rdata <= 0;
      log_q.delete();
    end else begin
      aw_cnt  <= aw_hs ? 0 : (awvalid ? aw_cnt + 1 : 0);
      w_cnt   <= w_hs ? 0 : (wvalid ? w_cnt + 1 : 0);
      aw_have <= wr_fire ? 1'b0 : (aw_have || aw_hs);
      w_have  <= wr_fire ? 1'b0 : (w_have || w_hs);
      if (aw_hs) aw_a <= awaddr;
      if (w_hs)  w_d  <= wdata;
      if (wr_fire) begin
        bvalid <= 1'b1;
        bresp  <= (b_err && wa[7:0] == 8'h04) ? 2'd2 : 2'd0;
        if (wa[7:0] == 8'h00) ra <= wd;
        if (wa[7:0] == 8'h04) rb <= wd;
        if (wa[7:0] == 8'h08) rctrl <= wd;
        log_q.push_back('{1'b1, wa, wd});
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
      if (ar_hs) begin
        rvalid <= 1'b1;
        rresp  <= 2'd0;
        rdata  <= rd_val;
        log_q.push_back('{1'b0, araddr, rd_val});
        if (araddr[7:0] == 8'h0C) stat_reads <= stat_reads + 1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_cfg(input int awd, input int wdl, input int sz,
                           input bit nev, input bit be);
    aw_dly = awd; w_dly = wdl; stat_zero_n = sz;
    stat_never = nev; b_err = be;
    sl_clr = 1'b1;
    tick();
    sl_clr = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_accept", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // drive one command, wait for its result and score it
  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ed, input logic [1:0] ee,
                     input int hold, output int lat);
    exp_t e;
    int   n = 0;
    exp_q.push_back('{ed, ee});
    send(a, b);
    while (!res_valid && n < 2000) begin
      tick();
      n++;
    end
    lat = n + 1;
    e = exp_q.pop_front();
    check("res_valid_seen", res_valid, 1'b1);
    check("res_data", res_data, e.data);
    check("res_err", res_err, e.err);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", res_valid, 1'b1);
      check("hold_data", res_data, e.data);
      check("hold_err", res_err, e.err);
      check("hold_cmd_ready", cmd_ready, 1'b0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("cmd_ready_back", cmd_ready, 1'b1);
  endtask

  function automatic int count(input bit we, input logic [7:0] a);
    int c = 0;
    foreach (log_q[i])
      if (log_q[i].we == we && log_q[i].addr[7:0] == a) c++;
    return c;
  endfunction

  logic [31:0] ea[6];
  bit          ewe[6];
  logic [31:0] ewd[6];
  int          lat;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_a = 0; cmd_b = 0; sl_clr = 1'b0;
    aw_dly = 0; w_dly = 0; stat_zero_n = 0; stat_never = 0; b_err = 0;
    repeat (3) tick();
    check("rst_valids", {awvalid, wvalid, bready, arvalid, rready,
                         res_valid, busy}, 7'h0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_res", {res_data, res_err}, 34'h0);
    check("rst_addr_data", {awaddr, araddr, wdata}, 96'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 10 + 20, zero-wait slave: full sequence in order
    slave_cfg(0, 0, 0, 0, 0);
    run(32'h10, 32'h20, 32'h30, 2'd0, 0, lat);
    check("lat_min13", lat >= 13, 1'b1);
    ea  = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h08};
    ewe = '{1, 1, 1, 0, 0, 1};
    ewd = '{32'h10, 32'h20, 32'hFFFF_FFFF, 0, 0, 32'h0};
    check("t1_len", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      check("t1_addr", log_q[i].addr, ea[i]);
      check("t1_we", log_q[i].we, ewe[i]);
      if (ewe[i]) check("t1_wdata", log_q[i].data, ewd[i]);
    end
    check("wstrb", wstrb, 4'hF);

    // overflow with AW/W skew: no duplicated writes
    slave_cfg(3, 2, 0, 0, 0);
    run(32'hFFFF_FFFF, 32'h1, 32'h0, 2'd0, 0, lat);
    check("t2_len", log_q.size(), 6);
    check("t2_wr_a", count(1, 8'h00), 1);
    check("t2_wr_b", count(1, 8'h04), 1);
    check("t2_wr_ctrl", count(1, 8'h08), 2);

    // STAT busy for 5 reads
    slave_cfg(0, 0, 5, 0, 0);
    run(32'hFFFF_FFF6, 32'h5, 32'hFFFF_FFFB, 2'd0, 0, lat);
    check("t3_stat_reads", count(0, 8'h0C), 6);
    check("t3_res_reads", count(0, 8'h10), 1);

    // STAT never completes: timeout after POLL_LIMIT reads
    slave_cfg(0, 0, 0, 1, 0);
    run(32'h7, 32'h8, 32'h0, 2'd2, 0, lat);
    check("t4_stat_reads", count(0, 8'h0C), 8);
    check("t4_res_reads", count(0, 8'h10), 0);
    check("t4_last_addr", log_q[log_q.size()-1].addr, 32'h08);
    check("t4_last_data", log_q[log_q.size()-1].data, 32'h0);
    check("t4_ctrl", rctrl, 32'h0);

    // bresp error on B write: abort, stable result while held
    slave_cfg(0, 0, 0, 0, 1);
    run(32'h1, 32'h2, 32'h0, 2'd1, 5, lat);
    repeat (5) tick();
    check("t5_len", log_q.size(), 2);

    // asynchronous reset mid-POLL, then a clean command
    slave_cfg(0, 0, 0, 1, 0);
    send(32'h3, 32'h4);
    for (int n = 0; n < 200 && stat_reads < 2; n++) tick();
    check("t6_in_poll", stat_reads >= 2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_valids", {awvalid, wvalid, bready, arvalid, rready,
                        res_valid, busy}, 7'h0);
    check("t6_cmd_ready", cmd_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    tick();
    slave_cfg(0, 0, 0, 0, 0);
    run(32'd100, 32'd200, 32'd300, 2'd0, 0, lat);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
